// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- VGA horizontal/vertical timing generator.
//
// Purpose: runs one SYNC -> BACK -> ACTIVE -> FRONT state machine per axis,
// advancing on pix_en ticks, and presents registered counts and flags that
// always describe the same pixel position.
//
// Ports:
//   clk            system clock, all state changes on its rising edge
//   rst_n          asynchronous active-low reset
//   pix_en         pixel tick qualifier
//   count_h        horizontal position, 0 = first sync pixel
//   count_v        vertical line, 0 = first sync line
//   h_sync, v_sync active-low sync pulses
//   active         high inside the visible region of both axes
//   frame_start    one-cycle pulse when the position wraps to (0,0)
//   h/v_left/right_margin  constant visible-region bounds (inclusive)
//   frame_cnt      frame counter, live only with VGA_FRAME_CNT_EN defined
//
// Configuration macro: VGA_FRAME_CNT_EN (undefined -> frame_cnt tied to 0).
// The width parameters REZ_MAX_WIDTH and *_MARGIN_WIDTH are the shared
// width set used by the downstream colour-assignment stage.
//
// state  | meaning
// SYNC   | sync pulse asserted (low)
// BACK   | back porch
// ACTIVE | visible pixels / lines
// FRONT  | front porch
module vga_sync_gen #(
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int REZ_MAX_WIDTH   = 10,
  parameter int HL_MARGIN_WIDTH = 8,
  parameter int HR_MARGIN_WIDTH = 10,
  parameter int VL_MARGIN_WIDTH = 6,
  parameter int VR_MARGIN_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pix_en,
  output logic [REZ_MAX_WIDTH-1:0]   count_h,
  output logic [REZ_MAX_WIDTH-1:0]   count_v,
  output logic                       h_sync,
  output logic                       v_sync,
  output logic                       active,
  output logic                       frame_start,
  output logic [HL_MARGIN_WIDTH-1:0] h_left_margin,
  output logic [HR_MARGIN_WIDTH-1:0] h_right_margin,
  output logic [VL_MARGIN_WIDTH-1:0] v_left_margin,
  output logic [VR_MARGIN_WIDTH-1:0] v_right_margin,
  output logic [7:0]                 frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [REZ_MAX_WIDTH-1:0] H_SYNC_END = REZ_MAX_WIDTH'(H_SYNC - 1);
  localparam logic [REZ_MAX_WIDTH-1:0] H_BACK_END = REZ_MAX_WIDTH'(H_SYNC + H_BP - 1);
  localparam logic [REZ_MAX_WIDTH-1:0] H_ACT_END  = REZ_MAX_WIDTH'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [REZ_MAX_WIDTH-1:0] H_LAST     = REZ_MAX_WIDTH'(H_TOTAL - 1);
  localparam logic [REZ_MAX_WIDTH-1:0] V_SYNC_END = REZ_MAX_WIDTH'(V_SYNC - 1);
  localparam logic [REZ_MAX_WIDTH-1:0] V_BACK_END = REZ_MAX_WIDTH'(V_SYNC + V_BP - 1);
  localparam logic [REZ_MAX_WIDTH-1:0] V_ACT_END  = REZ_MAX_WIDTH'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [REZ_MAX_WIDTH-1:0] V_LAST     = REZ_MAX_WIDTH'(V_TOTAL - 1);

  localparam logic [1:0] ST_SYNC   = 2'd0;
  localparam logic [1:0] ST_BACK   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_FRONT  = 2'd3;

  logic [1:0]               h_state, v_state;
  logic [1:0]               h_state_nxt, v_state_nxt;
  logic                     h_end, v_end, h_wrap, v_wrap;
  logic [REZ_MAX_WIDTH-1:0] count_h_nxt, count_v_nxt;
  // Cleared by reset; the first pix_en tick afterwards only presents (0,0).
  logic                     started;

  assign h_left_margin  = HL_MARGIN_WIDTH'(H_SYNC + H_BP);
  assign h_right_margin = HR_MARGIN_WIDTH'(H_SYNC + H_BP + H_ACTIVE - 1);
  assign v_left_margin  = VL_MARGIN_WIDTH'(V_SYNC + V_BP);
  assign v_right_margin = VR_MARGIN_WIDTH'(V_SYNC + V_BP + V_ACTIVE - 1);

  always_comb begin
    h_end = 1'b0;
    case (h_state)
      ST_SYNC:   h_end = (count_h == H_SYNC_END);
      ST_BACK:   h_end = (count_h == H_BACK_END);
      ST_ACTIVE: h_end = (count_h == H_ACT_END);
      default:   h_end = (count_h == H_LAST);
    endcase
    // The 2-bit encoding wraps FRONT back to SYNC.
    h_state_nxt = h_end ? h_state + 2'd1 : h_state;
    h_wrap      = (count_h == H_LAST);
    count_h_nxt = h_wrap ? '0 : count_h + REZ_MAX_WIDTH'(1);

    v_end = 1'b0;
    case (v_state)
      ST_SYNC:   v_end = (count_v == V_SYNC_END);
      ST_BACK:   v_end = (count_v == V_BACK_END);
      ST_ACTIVE: v_end = (count_v == V_ACT_END);
      default:   v_end = (count_v == V_LAST);
    endcase
    v_wrap      = (count_v == V_LAST);
    // The vertical axis only moves on the tick that ends a line.
    v_state_nxt = (h_wrap && v_end) ? v_state + 2'd1 : v_state;
    count_v_nxt = !h_wrap ? count_v : (v_wrap ? '0 : count_v + REZ_MAX_WIDTH'(1));
  end

  // Flags are registered from the same next-state values as the counts,
  // so counts and flags change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_h     <= '0;
      count_v     <= '0;
      h_state     <= ST_SYNC;
      v_state     <= ST_SYNC;
      h_sync      <= 1'b0;
      v_sync      <= 1'b0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      started     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        if (!started) begin
          started <= 1'b1;
        end else begin
          count_h     <= count_h_nxt;
          count_v     <= count_v_nxt;
          h_state     <= h_state_nxt;
          v_state     <= v_state_nxt;
          h_sync      <= (h_state_nxt != ST_SYNC);
          v_sync      <= (v_state_nxt != ST_SYNC);
          active      <= (h_state_nxt == ST_ACTIVE) && (v_state_nxt == ST_ACTIVE);
          frame_start <= h_wrap && v_wrap;
        end
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 8'd0;
    end else if (pix_en && started && h_wrap && v_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_SYNC, default 96: horizontal sync width, in pixel ticks.
REQ-002 Parameter H_BP, default 48: horizontal back porch, in pixel ticks.
REQ-003 Parameter H_ACTIVE, default 640: horizontal visible pixels.
REQ-004 Parameter H_FP, default 16: horizontal front porch, in pixel ticks.
REQ-005 Parameters V_SYNC, V_BP, V_ACTIVE, V_FP, defaults 2, 33, 480, 10: vertical equivalents, in lines.
REQ-006 Port widths SHALL come from the shared width-parameter include: REZ_MAX_WIDTH, HL/HR/VL/VR_MARGIN_WIDTH.
REQ-007 Clk, input, 1: single system clock; all state SHALL change on its rising edge.
REQ-008 Rst_n, input, 1: asynchronous, active-low reset.
REQ-009 Pix_en, input, 1: pixel tick qualifier; counters SHALL advance only on cycles where it is high.
REQ-010 Count_h, output, REZ_MAX_WIDTH: horizontal position, 0 = first sync pixel.
REQ-011 Count_v, output, REZ_MAX_WIDTH: vertical line, 0 = first sync line.
REQ-012 H_sync and V_sync, outputs, 1 each: active-low sync pulses.
REQ-013 Active, output, 1: high when both axes are in their visible region.
REQ-014 Frame_start, output, 1: one-cycle pulse at the start of each frame.
REQ-015 H_left_margin, H_right_margin, V_left_margin, V_right_margin, outputs, margin widths: active-region bounds for the colour-assignment stage.
REQ-016 Frame_cnt, output, 8: frame counter (see Configuration).

Function
REQ-017 H_TOTAL SHALL equal H_SYNC+H_BP+H_ACTIVE+H_FP (default 800); V_TOTAL SHALL equal the vertical sum (default 525).
REQ-018 Each axis SHALL run a state machine SYNC -> BACK -> ACTIVE -> FRONT -> SYNC; the transition SHALL fire on the Pix_en tick at which the running count reaches the end of the current phase.
REQ-019 On a Pix_en tick, Count_h SHALL increment; at H_TOTAL-1 it SHALL wrap to 0.
REQ-020 Count_v SHALL increment only on the tick where Count_h wraps, and SHALL itself wrap from V_TOTAL-1 to 0.
REQ-021 H_sync SHALL be 0 while the horizontal state is SYNC (Count_h 0..H_SYNC-1), else 1; V_sync SHALL follow the same rule per line.
REQ-022 Margin outputs SHALL be constant:
- H_left_margin = H_SYNC+H_BP (144)
- H_right_margin = H_left_margin+H_ACTIVE-1 (783)
- V_left_margin = V_SYNC+V_BP (35)
- V_right_margin = V_left_margin+V_ACTIVE-1 (514)
REQ-023 Active SHALL be 1 exactly when Count_h and Count_v are each within their inclusive margins.
REQ-024 All outputs SHALL be registered and consistent with the Count_h/Count_v values presented in the same cycle, with zero skew between counts and flags.
REQ-025 Frame_start SHALL pulse for one Clk cycle on the tick where both counts wrap to 0.
REQ-026 While Pix_en is low, all outputs SHALL hold their values, except Frame_start, which SHALL be 0.
REQ-027 Pix_en held high continuously SHALL be legal and give one pixel per Clk.

Reset
REQ-028 Rst_n low SHALL immediately force the following, regardless of Clk:
- Count_h = 0 and Count_v = 0
- both state machines to SYNC
- H_sync = 0 and V_sync = 0
- Active = 0, Frame_start = 0, Frame_cnt = 0
REQ-029 Reset asserted mid-line or mid-frame SHALL discard the position; after release, counting SHALL restart from (0,0) on the first Pix_en tick, with no Frame_start pulse for that first tick.

Configuration
REQ-030 With macro VGA_FRAME_CNT_EN defined, Frame_cnt SHALL increment (mod 256) on every Frame_start pulse.
REQ-031 Without VGA_FRAME_CNT_EN, Frame_cnt SHALL be tied to 0 and no counter logic SHALL be synthesised.

Verification
REQ-032 Reset release with Pix_en=1 -> Count_h steps 0,1,2...; H_sync=0 for cycles 0..95 and rises at Count_h=96.
REQ-033 Run to Count_h=799 -> next tick gives Count_h=0 and Count_v=1; Active stays 0 throughout this line.
REQ-034 At Count_v=35: Count_h=143 -> Active=0; Count_h=144 -> Active=1; Count_h=783 -> Active=1; Count_h=784 -> Active=0.
REQ-035 Full frame of 420000 ticks -> exactly one Frame_start pulse at (0,0); V_sync=0 only for lines 0..1; Frame_cnt goes 0 -> 1 with the macro defined, stays 0 without it.
REQ-036 Pix_en toggled 1,0,1,0 -> counts advance every other Clk and Frame_start never lasts more than one cycle.
REQ-037 Rst_n pulsed low at (400,200) with no Clk edge -> outputs go to reset values immediately; after release, counting restarts at (0,0).
